rv32i_instr_encoder: RTL

- Streaming RV32I instruction encoder; the inverse of the instruction decoder.
- Accepts decoded fields (format, opcode, registers, funct3/funct7, full 32-bit immediate) over a valid/ready interface.
- Emits the packed 32-bit instruction word with a sequential word address, for loading instruction memory or generating test programs.
- Two-stage pipeline with backpressure, immediate range checking, and output/error counters.

---
 rtl/rv32i_instr_encoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rv32i_instr_encoder.sv
// Streaming RV32I instruction encoder: packs decoded field bundles into 32-bit words
// through a two-stage valid/ready pipeline with address assignment and counters.
module rv32i_instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_restart,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [ADDR_W:0]   enc_count,
  output logic [15:0]       err_count
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   ENC_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [31:0]       NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fields_t;

  function automatic logic field_err(input logic [2:0] fmt, input logic [6:0] op,
                                     input logic [31:0] imm);
    logic bad;
    case (fmt)
      3'd0:       bad = 1'b0;
      3'd1, 3'd2: bad = !((imm[31:11] == '0) || (imm[31:11] == '1));
      3'd3:       bad = !((imm[31:12] == '0) || (imm[31:12] == '1)) || imm[0];
      3'd4:       bad = (imm[11:0] != 12'd0);
      3'd5:       bad = !((imm[31:20] == '0) || (imm[31:20] == '1)) || imm[0];
      default:    bad = 1'b1;
    endcase
    return bad || (op[1:0] != 2'b11);
  endfunction

  function automatic logic [31:0] encode(input fields_t f);
    logic [31:0] w;
    case (f.fmt)
      3'd0:    w = {f.f7, f.rs2, f.rs1, f.f3, f.rd, f.op};
      3'd1:    w = {f.imm[11:0], f.rs1, f.f3, f.rd, f.op};
      3'd2:    w = {f.imm[11:5], f.rs2, f.rs1, f.f3, f.imm[4:0], f.op};
      3'd3:    w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.f3, f.imm[4:1], f.imm[11], f.op};
      3'd4:    w = {f.imm[31:12], f.rd, f.op};
      3'd5:    w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.op};
      default: w = NOP;
    endcase
    return w;
  endfunction

  fields_t           s1_f_q, s1_f_d;
  logic              s1_v_q, s1_v_d, s1_err_q, s1_err_d;
  logic              s2_v_q, s2_v_d, out_err_q, out_err_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   enc_q, enc_d;
  logic [15:0]       errc_q, errc_d;
  logic              adv1, adv2, accept, handshake;
  fields_t           in_f;

  assign in_f = '{fmt: in_fmt, op: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                  f3: in_funct3, f7: in_funct7, imm: in_imm};

  // Handshake/advance logic and next state for both stages and the counters.
  always_comb begin
    adv2      = !s2_v_q || out_ready;
    adv1      = !s1_v_q || adv2;
    in_ready  = adv1 && !in_restart;
    accept    = in_valid && in_ready;
    handshake = s2_v_q && out_ready && !in_restart;

    s1_f_d      = accept ? in_f : s1_f_q;
    s1_err_d    = accept ? field_err(in_fmt, in_opcode, in_imm) : s1_err_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    if (adv2 && s1_v_q) begin
      // Illegal bundles still occupy a slot, so the layout of later words is unchanged.
      out_instr_d = s1_err_q ? NOP : encode(s1_f_q);
      out_err_d   = s1_err_q;
    end else begin
      out_instr_d = out_instr_q;
      out_err_d   = out_err_q;
    end

    if (in_restart) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
      addr_d = BASE;
      enc_d  = '0;
      errc_d = 16'd0;
    end else begin
      s1_v_d = adv1 ? in_valid : s1_v_q;
      s2_v_d = adv2 ? s1_v_q : s2_v_q;
      addr_d = handshake ? addr_q + ADDR_W'(1) : addr_q;
      enc_d  = (handshake && enc_q != ENC_MAX) ? enc_q + (ADDR_W+1)'(1) : enc_q;
      errc_d = (handshake && out_err_q && errc_q != 16'hFFFF) ? errc_q + 16'd1 : errc_q;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_f_q      <= '0;
      s1_v_q      <= 1'b0;
      s1_err_q    <= 1'b0;
      s2_v_q      <= 1'b0;
      out_err_q   <= 1'b0;
      out_instr_q <= 32'd0;
      addr_q      <= BASE;
      enc_q       <= '0;
      errc_q      <= 16'd0;
    end else begin
      s1_f_q      <= s1_f_d;
      s1_v_q      <= s1_v_d;
      s1_err_q    <= s1_err_d;
      s2_v_q      <= s2_v_d;
      out_err_q   <= out_err_d;
      out_instr_q <= out_instr_d;
      addr_q      <= addr_d;
      enc_q       <= enc_d;
      errc_q      <= errc_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign out_addr  = addr_q;
  assign enc_count = enc_q;
  assign err_count = errc_q;

endmodule
